// File: rtl/dino_pkg.sv
// Shared types and widths for the dino game controller.
package dino_pkg;

  localparam int SCORE_W = 16;
  localparam int LOCK_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/dino_tick_div.sv
// Frame-tick divider: counts 0..DIV-1 while enabled and flags the last count.
module dino_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  // NOTE: registered state is only ever assigned with <= inside always_ff.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = en & ~clr & w_last;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino game control FSM (IDLE/RUN/OVER) with frame ticks and restart lockout.
// Optional high-score tracking is built only when DINO_HISCORE_EN is defined.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int TICK_DIV  = 416667,
  parameter int OVER_HOLD = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic               collide,
  input  logic [SCORE_W-1:0] score,
  output logic               game_start,
  output logic               game_over,
  output logic               game_tick,
  output logic               running,
  output logic [SCORE_W-1:0] hiscore,
  output logic               new_hi
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_btn_prev;
  logic               r_game_start;
  logic               r_game_over;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic               w_btn_rise;
  logic               w_lock_done;
  logic               w_start_acc;
  logic               w_over_acc;
  logic               w_frame_tick;
  logic [SCORE_W-1:0] w_hiscore;
  logic               w_new_hi;

  assign w_btn_rise  = btn & ~r_btn_prev;
  assign w_lock_done = (r_lock_cnt >= LOCK_W'(OVER_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_btn_prev   <= 1'b0;
      r_game_start <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_prev   <= btn;
      r_game_start <= w_start_acc;
      r_game_over  <= w_over_acc;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_over_acc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_rise) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (collide) begin
          w_state_nxt = ST_OVER;
          w_over_acc  = 1'b1;
        end
      end
      ST_OVER: begin
        if (w_lock_done && w_btn_rise) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter restarts during the first RUN cycle, so the first tick lands
  // TICK_DIV cycles after game_start; it free-runs through OVER for lockout.
  dino_tick_div #(
    .DIV (TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_game_start),
    .en   (r_state != ST_IDLE),
    .tick (w_frame_tick)
  );

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_OVER) begin
      r_lock_cnt <= '0;
    end else if (w_frame_tick && !w_lock_done) begin
      r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
    end
  end

`ifdef DINO_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;
  logic               r_new_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hiscore <= '0;
      r_new_hi  <= 1'b0;
    end else if (w_start_acc) begin
      r_new_hi  <= 1'b0;
    end else if (w_over_acc && (score > r_hiscore)) begin
      r_hiscore <= score;
      r_new_hi  <= 1'b1;
    end
  end

  assign w_hiscore = r_hiscore;
  assign w_new_hi  = r_new_hi;
`else
  logic w_score_unused;
  assign w_score_unused = ^score;
  assign w_hiscore      = '0;
  assign w_new_hi       = 1'b0;
`endif

  // Outputs are forced low while rst is high, even before the first edge.
  assign game_start = r_game_start & ~rst;
  assign game_over  = r_game_over & ~rst;
  assign game_tick  = w_frame_tick & (r_state == ST_RUN) & ~rst;
  assign running    = (r_state == ST_RUN) & ~rst;
  assign hiscore    = rst ? '0 : w_hiscore;
  assign new_hi     = w_new_hi & ~rst;

endmodule
